// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: EX-side push and MEM-side pop handshakes of the EX->MEM result buffer.
interface alu_result_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic [3:0]  in_flag;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en;
    logic        out_ovf;
    modport master (
        output in_valid, in_op, in_result, in_overflow, in_underflow, in_flag, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wr_en, out_ovf
    );
    modport slave (
        input  in_valid, in_op, in_result, in_overflow, in_underflow, in_flag, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wr_en, out_ovf
    );
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: EX->MEM result FIFO with compare-flag register and saturating overflow counter.
// Optional ALU_EXC_TRAP_EN: arithmetic overflow on ADD..MUL suppresses the write and raises exc_pending_o.
module alu_result_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_buffer_if.slave bus,
    input  logic               flush_i,
    input  logic               exc_ack_i,
    output logic [3:0]         cmp_flags_o,
    output logic [CNT_W-1:0]   ovf_count_o,
    output logic               exc_pending_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [4:0] OP_CMP = 5'd11;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
        logic        ovf;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           entry_d, head;
    logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]       cmp_flags_q, cmp_flags_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic             full, empty, push, pop, accept, ovf_in, trap;

    always_comb begin
        full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        empty       = wr_ptr_q == rd_ptr_q;
        push        = bus.in_valid && !full;
        pop         = !empty && bus.out_ready;
        accept      = push && !flush_i;
        ovf_in      = bus.in_overflow || bus.in_underflow;
        wr_ptr_d    = flush_i ? '0 : wr_ptr_q + (PW+1)'(push);
        rd_ptr_d    = flush_i ? '0 : rd_ptr_q + (PW+1)'(pop);
        cmp_flags_d = (accept && bus.in_op == OP_CMP) ? bus.in_flag : cmp_flags_q;
        ovf_count_d = (accept && ovf_in && ovf_count_q != '1) ? ovf_count_q + CNT_W'(1) : ovf_count_q;
        // CMP and the reserved opcodes above it never write the register file
        entry_d     = '{result: bus.in_result, rd: bus.in_rd,
                        wr_en: (bus.in_op < OP_CMP) && (bus.in_rd != 5'd0) && !trap, ovf: ovf_in};
        head        = mem_q[rd_ptr_q[PW-1:0]];
    end

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_result = empty ? '0 : head.result;
    assign bus.out_rd     = empty ? '0 : head.rd;
    assign bus.out_wr_en  = !empty && head.wr_en;
    assign bus.out_ovf    = !empty && head.ovf;
    assign cmp_flags_o    = cmp_flags_q;
    assign ovf_count_o    = ovf_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmp_flags_q <= '0;
            ovf_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmp_flags_q <= cmp_flags_d;
            ovf_count_q <= ovf_count_d;
            if (accept) mem_q[wr_ptr_q[PW-1:0]] <= entry_d;
        end
    end

`ifdef ALU_EXC_TRAP_EN
    logic exc_pending_q, exc_pending_d;
    assign trap = ovf_in && (bus.in_op <= 5'd4);
    // a new trap outranks an acknowledge arriving in the same cycle
    assign exc_pending_d = (accept && trap) ? 1'b1 : exc_ack_i ? 1'b0 : exc_pending_q;
    assign exc_pending_o = exc_pending_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exc_pending_q <= 1'b0;
        else        exc_pending_q <= exc_pending_d;
    end
`else
    logic unused_exc_ack;
    assign trap           = 1'b0;
    assign unused_exc_ack = exc_ack_i;
    assign exc_pending_o  = 1'b0;
`endif
endmodule
